// File: rtl/udp_pkg.sv
// udp_pkg: constants and state encoding shared by the UDP send/receive blocks
package udp_pkg;
    localparam int UDP_HDR_BYTES = 8;
    localparam logic [1:0] OP_UDP = 2'h1;
    localparam logic [15:0] DEFAULT_LOCAL_PORT = 16'h0400;
    typedef enum logic [1:0] {IDLE, HDR1, PAYLOAD, DROP} udp_rx_state_e;
endpackage

// File: rtl/udp_keep_gen.sv
// udp_keep_gen: MSB-first byte-enable mask for the final 1..4 bytes of a payload
module udp_keep_gen (
    input  logic [2:0] bytes_in,
    output logic [3:0] keep_out
);
    // one enable per valid byte, byte 0 on the MSB
    always_comb begin
        keep_out = bytes_in == 3'd1 ? 4'b1000 :
                   bytes_in == 3'd2 ? 4'b1100 :
                   bytes_in == 3'd3 ? 4'b1110 : 4'b1111;
    end
endmodule

// File: rtl/udp_recv.sv
// udp_recv: parse UDP header, filter on destination port, strip header and trim payload to UDP length
module udp_recv
    import udp_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT     = DEFAULT_LOCAL_PORT,
    parameter bit          PORT_FILTER_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        data_valid_in,
    input  logic [3:0]  data_keep_in,
    input  logic        data_last_in,
    input  logic [1:0]  op,
    input  logic [31:0] ip_addr_in,
    output logic [31:0] data_out,
    output logic        data_valid_out,
    output logic [3:0]  data_keep_out,
    output logic        data_last_out,
    output logic [31:0] ip_addr_out,
    output logic [15:0] src_port_out,
    output logic [15:0] dest_port_out,
    output logic [15:0] length_out,
    output logic        err_out
);
    udp_rx_state_e state_q, state_d;
    logic [15:0] src_q, src_d, dest_q, dest_d, rem_q, rem_d;
    logic [31:0] ip_q, ip_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d, last_q, last_d, err_q, err_d;
    logic [3:0]  keep_q, keep_d, final_keep;
    logic [31:0] ip_out_q, ip_out_d;
    logic [15:0] src_out_q, src_out_d, dest_out_q, dest_out_d, len_out_q, len_out_d;
    logic [15:0] len_in;
    logic        filtered;

    assign len_in   = data_in[31:16];
    assign filtered = PORT_FILTER_EN && dest_q != LOCAL_PORT;

    udp_keep_gen u_keep_gen (
        .bytes_in (rem_q[2:0]),
        .keep_out (final_keep)
    );

    // next-state, header capture and registered payload output per accepted word
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dest_d     = dest_q;
        ip_d       = ip_q;
        rem_d      = rem_q;
        data_d     = '0;
        valid_d    = 1'b0;
        keep_d     = '0;
        last_d     = 1'b0;
        err_d      = 1'b0;
        ip_out_d   = ip_out_q;
        src_out_d  = src_out_q;
        dest_out_d = dest_out_q;
        len_out_d  = len_out_q;
        if (data_valid_in) begin
            case (state_q)
                IDLE: begin
                    if (op != OP_UDP) begin
                        state_d = data_last_in ? IDLE : DROP;
                    end else begin
                        src_d   = data_in[31:16];
                        dest_d  = data_in[15:0];
                        ip_d    = ip_addr_in;
                        err_d   = data_last_in;
                        state_d = data_last_in ? IDLE : HDR1;
                    end
                end
                HDR1: begin
                    if (len_in <= 16'(UDP_HDR_BYTES) || filtered) begin
                        err_d   = len_in < 16'(UDP_HDR_BYTES);
                        state_d = data_last_in ? IDLE : DROP;
                    end else if (data_last_in) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rem_d      = len_in - 16'(UDP_HDR_BYTES);
                        len_out_d  = len_in - 16'(UDP_HDR_BYTES);
                        src_out_d  = src_q;
                        dest_out_d = dest_q;
                        ip_out_d   = ip_q;
                        state_d    = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    data_d  = data_in;
                    valid_d = 1'b1;
                    if (rem_q > 16'd4) begin
                        keep_d  = data_keep_in;
                        rem_d   = rem_q - 16'd4;
                        last_d  = data_last_in;
                        err_d   = data_last_in;
                        state_d = data_last_in ? IDLE : PAYLOAD;
                    end else begin
                        keep_d  = final_keep;
                        rem_d   = '0;
                        last_d  = 1'b1;
                        state_d = data_last_in ? IDLE : DROP;
                    end
                end
                DROP: state_d = data_last_in ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
        end
    end

    // state and output registers; reset abandons any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dest_q     <= '0;
            ip_q       <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            ip_out_q   <= '0;
            src_out_q  <= '0;
            dest_out_q <= '0;
            len_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dest_q     <= dest_d;
            ip_q       <= ip_d;
            rem_q      <= rem_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            keep_q     <= keep_d;
            last_q     <= last_d;
            err_q      <= err_d;
            ip_out_q   <= ip_out_d;
            src_out_q  <= src_out_d;
            dest_out_q <= dest_out_d;
            len_out_q  <= len_out_d;
        end
    end

    assign data_out       = data_q;
    assign data_valid_out = valid_q;
    assign data_keep_out  = keep_q;
    assign data_last_out  = last_q;
    assign err_out        = err_q;
    assign ip_addr_out    = ip_out_q;
    assign src_port_out   = src_out_q;
    assign dest_port_out  = dest_out_q;
    assign length_out     = len_out_q;
endmodule

// File: tb/tb_udp_recv.sv
// tb_udp_recv: directed vectors for udp_recv, filtered and unfiltered instances side by side
module tb_udp_recv;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic        data_valid_in = 1'b0;
    logic [3:0]  data_keep_in = '0;
    logic        data_last_in = 1'b0;
    logic [1:0]  op = 2'h1;
    logic [31:0] ip_addr_in = 32'hC0A8_0001;
    logic [31:0] data_out, ip_addr_out, data_out2, ip_addr_out2;
    logic        data_valid_out, data_last_out, err_out;
    logic        data_valid_out2, data_last_out2, err_out2;
    logic [3:0]  data_keep_out, data_keep_out2;
    logic [15:0] src_port_out, dest_port_out, length_out;
    logic [15:0] src_port_out2, dest_port_out2, length_out2;
    int checks = 0;
    int errors = 0;

    udp_recv dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid_in(data_valid_in),
        .data_keep_in(data_keep_in), .data_last_in(data_last_in), .op(op), .ip_addr_in(ip_addr_in),
        .data_out(data_out), .data_valid_out(data_valid_out), .data_keep_out(data_keep_out),
        .data_last_out(data_last_out), .ip_addr_out(ip_addr_out), .src_port_out(src_port_out),
        .dest_port_out(dest_port_out), .length_out(length_out), .err_out(err_out)
    );

    udp_recv #(.PORT_FILTER_EN(1'b0)) dut_nf (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid_in(data_valid_in),
        .data_keep_in(data_keep_in), .data_last_in(data_last_in), .op(op), .ip_addr_in(ip_addr_in),
        .data_out(data_out2), .data_valid_out(data_valid_out2), .data_keep_out(data_keep_out2),
        .data_last_out(data_last_out2), .ip_addr_out(ip_addr_out2), .src_port_out(src_port_out2),
        .dest_port_out(dest_port_out2), .length_out(length_out2), .err_out(err_out2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] o);
        data_in = d;
        data_keep_in = k;
        data_last_in = l;
        op = o;
        data_valid_in = 1'b1;
        @(posedge clk);
        #1;
        data_valid_in = 1'b0;
    endtask

    task automatic gap();
        data_valid_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input string tag);
        check({tag, "_valid"}, {31'd0, data_valid_out}, 32'd0);
        check({tag, "_err"}, {31'd0, err_out}, 32'd0);
        check({tag, "_keep"}, {28'd0, data_keep_out}, 32'd0);
    endtask

    initial begin
        #3;
        check("rst_valid", {31'd0, data_valid_out}, 32'd0);
        check("rst_len", {16'd0, length_out}, 32'd0);
        check("rst_ip", ip_addr_out, 32'd0);
        #9 reset = 1'b0;
        @(posedge clk);
        #1;
        // nominal 7-byte datagram
        wr(32'h0400_0400, 4'hF, 1'b0, 2'h1);
        quiet("nom_h0");
        wr(32'h000F_0000, 4'hF, 1'b0, 2'h1);
        quiet("nom_h1");
        check("nom_len", {16'd0, length_out}, 32'd7);
        wr(32'hAABB_CCDD, 4'hF, 1'b0, 2'h1);
        check("nom_w0_valid", {31'd0, data_valid_out}, 32'd1);
        check("nom_w0_data", data_out, 32'hAABB_CCDD);
        check("nom_w0_keep", {28'd0, data_keep_out}, 32'hF);
        check("nom_w0_last", {31'd0, data_last_out}, 32'd0);
        check("nom_src", {16'd0, src_port_out}, 32'h0400);
        check("nom_dst", {16'd0, dest_port_out}, 32'h0400);
        check("nom_ip", ip_addr_out, 32'hC0A8_0001);
        wr(32'h1122_3300, 4'hE, 1'b1, 2'h1);
        check("nom_w1_data", data_out, 32'h1122_3300);
        check("nom_w1_keep", {28'd0, data_keep_out}, 32'hE);
        check("nom_w1_last", {31'd0, data_last_out}, 32'd1);
        check("nom_w1_err", {31'd0, err_out}, 32'd0);
        gap();
        quiet("nom_idle");
        check("nom_idle_last", {31'd0, data_last_out}, 32'd0);
        // padding trim, back-to-back first word afterwards
        ip_addr_in = 32'h0A00_0002;
        wr(32'h1111_0400, 4'hF, 1'b0, 2'h1);
        wr(32'h000A_0000, 4'hF, 1'b0, 2'h1);
        wr(32'h1234_5678, 4'hF, 1'b0, 2'h1);
        check("pad_valid", {31'd0, data_valid_out}, 32'd1);
        check("pad_keep", {28'd0, data_keep_out}, 32'hC);
        check("pad_last", {31'd0, data_last_out}, 32'd1);
        check("pad_len", {16'd0, length_out}, 32'd2);
        check("pad_src", {16'd0, src_port_out}, 32'h1111);
        check("pad_ip", ip_addr_out, 32'h0A00_0002);
        wr(32'h0, 4'hF, 1'b0, 2'h1);
        quiet("pad_p0");
        wr(32'h0, 4'hF, 1'b1, 2'h1);
        quiet("pad_p1");
        // port filter: dropped by filtered instance, accepted by unfiltered one
        wr(32'h2222_0401, 4'hF, 1'b0, 2'h1);
        wr(32'h000C_0000, 4'hF, 1'b0, 2'h1);
        check("flt_nf_len", {16'd0, length_out2}, 32'd4);
        wr(32'hDEAD_BEEF, 4'hF, 1'b1, 2'h1);
        quiet("flt");
        check("flt_hold_len", {16'd0, length_out}, 32'd2);
        check("flt_nf_valid", {31'd0, data_valid_out2}, 32'd1);
        check("flt_nf_data", data_out2, 32'hDEAD_BEEF);
        check("flt_nf_last", {31'd0, data_last_out2}, 32'd1);
        check("flt_nf_dst", {16'd0, dest_port_out2}, 32'h0401);
        // truncated payload: err coincides with last_out
        wr(32'h0400_0400, 4'hF, 1'b0, 2'h1);
        wr(32'h0014_0000, 4'hF, 1'b0, 2'h1);
        wr(32'hA1A1_A1A1, 4'hF, 1'b0, 2'h1);
        check("trc_w0_valid", {31'd0, data_valid_out}, 32'd1);
        check("trc_w0_err", {31'd0, err_out}, 32'd0);
        wr(32'hA2A2_A2A2, 4'hF, 1'b1, 2'h1);
        check("trc_w1_data", data_out, 32'hA2A2_A2A2);
        check("trc_w1_last", {31'd0, data_last_out}, 32'd1);
        check("trc_w1_err", {31'd0, err_out}, 32'd1);
        check("trc_w1_keep", {28'd0, data_keep_out}, 32'hF);
        gap();
        quiet("trc_after");
        // last during second header word
        wr(32'h0400_0400, 4'hF, 1'b0, 2'h1);
        wr(32'h000F_0000, 4'hF, 1'b1, 2'h1);
        check("hdr_trc_err", {31'd0, err_out}, 32'd1);
        check("hdr_trc_valid", {31'd0, data_valid_out}, 32'd0);
        // last on the first header word
        wr(32'h0400_0400, 4'hF, 1'b1, 2'h1);
        check("hdr0_err", {31'd0, err_out}, 32'd1);
        // bad length
        wr(32'h0400_0400, 4'hF, 1'b0, 2'h1);
        wr(32'h0004_0000, 4'hF, 1'b0, 2'h1);
        check("blen_err", {31'd0, err_out}, 32'd1);
        check("blen_valid", {31'd0, data_valid_out}, 32'd0);
        wr(32'h5555_5555, 4'hF, 1'b1, 2'h1);
        quiet("blen_drop");
        // zero-length datagram
        wr(32'h0400_0400, 4'hF, 1'b0, 2'h1);
        wr(32'h0008_0000, 4'hF, 1'b1, 2'h1);
        quiet("zlen");
        // non-UDP frame ignored
        wr(32'h0400_0400, 4'hF, 1'b0, 2'h2);
        quiet("op2_h0");
        wr(32'h000F_0000, 4'hF, 1'b0, 2'h1);
        quiet("op2_h1");
        wr(32'h7777_7777, 4'hF, 1'b1, 2'h1);
        quiet("op2_w");
        // valid gaps inside a frame
        wr(32'h3333_0400, 4'hF, 1'b0, 2'h1);
        gap();
        wr(32'h000F_0000, 4'hF, 1'b0, 2'h1);
        gap();
        quiet("gap_g0");
        wr(32'hCAFE_F00D, 4'hF, 1'b0, 2'h1);
        check("gap_w0_data", data_out, 32'hCAFE_F00D);
        check("gap_w0_valid", {31'd0, data_valid_out}, 32'd1);
        gap();
        gap();
        quiet("gap_g1");
        wr(32'hBEEF_0100, 4'hF, 1'b1, 2'h1);
        check("gap_w1_data", data_out, 32'hBEEF_0100);
        check("gap_w1_keep", {28'd0, data_keep_out}, 32'hE);
        check("gap_w1_last", {31'd0, data_last_out}, 32'd1);
        check("gap_w1_err", {31'd0, err_out}, 32'd0);
        check("gap_src", {16'd0, src_port_out}, 32'h3333);
        // asynchronous reset in PAYLOAD
        wr(32'h0400_0400, 4'hF, 1'b0, 2'h1);
        wr(32'h0010_0000, 4'hF, 1'b0, 2'h1);
        wr(32'h9999_9999, 4'hF, 1'b0, 2'h1);
        check("rmid_pre_valid", {31'd0, data_valid_out}, 32'd1);
        reset = 1'b1;
        #1;
        check("rmid_valid", {31'd0, data_valid_out}, 32'd0);
        check("rmid_data", data_out, 32'd0);
        check("rmid_len", {16'd0, length_out}, 32'd0);
        check("rmid_src", {16'd0, src_port_out}, 32'd0);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        wr(32'h4444_0400, 4'hF, 1'b0, 2'h1);
        quiet("rpost_h0");
        wr(32'h000D_0000, 4'hF, 1'b0, 2'h1);
        check("rpost_len", {16'd0, length_out}, 32'd5);
        wr(32'h0102_0304, 4'hF, 1'b0, 2'h1);
        check("rpost_w0_data", data_out, 32'h0102_0304);
        check("rpost_w0_last", {31'd0, data_last_out}, 32'd0);
        wr(32'h0500_0000, 4'hF, 1'b1, 2'h1);
        check("rpost_w1_keep", {28'd0, data_keep_out}, 32'h8);
        check("rpost_w1_last", {31'd0, data_last_out}, 32'd1);
        check("rpost_w1_err", {31'd0, err_out}, 32'd0);
        gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
